sobel_frame_ctrl: RTL and testbench

//  Frame scheduler for the Sobel datapath between the input pixel FIFO and output FIFO.
//  - Sequences one WIDTH x HEIGHT frame through fill, run and flush phases.
//  - Gates FIFO reads and writes, and drives the 3x3 window shift-enable and the zero-pad select.
//  - Provides the centre-pixel coordinates and a border flag, so the datapath emits 0 on image edges.

---
 rtl/sobel_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame scheduler for the Sobel datapath: sequences fill/run/flush of one frame,
// gates FIFO traffic and tracks the window-centre coordinates for border zeroing.
module sobel_frame_ctrl #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540,
    parameter int CW     = 10,
    parameter int RW     = 10,
    parameter int PW     = 19
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          in_empty,
    output logic          in_rd_en,
    input  logic          out_full,
    output logic          out_wr_en,
    output logic          px_advance,
    output logic          pad_sel,
    output logic [CW-1:0] cen_col,
    output logic [RW-1:0] cen_row,
    output logic          border,
    output logic          frame_start,
    output logic          frame_done,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

    localparam logic [PW-1:0] FILL_LAST = PW'(WIDTH + 1);
    localparam logic [PW-1:0] RUN_LAST  = PW'(WIDTH * HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);

    state_t        state, state_nx;
    logic [PW-1:0] p, p_nx;
    logic [CW-1:0] col_nx;
    logic [RW-1:0] row_nx;
    logic          active_nx;

    always_comb begin
        state_nx   = state;
        p_nx       = p;
        col_nx     = cen_col;
        row_nx     = cen_row;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        px_advance = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FILL;
                    p_nx     = '0;
                end
            end
            FILL: begin
                px_advance = !in_empty;
                in_rd_en   = !in_empty;
                if (!in_empty) begin
                    p_nx = p + 1'b1;
                    // A 2x2 frame has no RUN-phase writes at all.
                    if (p == FILL_LAST)
                        state_nx = (FILL_LAST == RUN_LAST) ? FLUSH : RUN;
                end
            end
            RUN: begin
                px_advance = !in_empty && !out_full;
                in_rd_en   = px_advance;
                out_wr_en  = px_advance;
                if (px_advance) begin
                    p_nx = p + 1'b1;
                    if (cen_col == COL_LAST) begin
                        col_nx = '0;
                        row_nx = cen_row + 1'b1;
                    end else begin
                        col_nx = cen_col + 1'b1;
                    end
                    if (p == RUN_LAST)
                        state_nx = FLUSH;
                end
            end
            FLUSH: begin
                px_advance = !out_full;
                out_wr_en  = !out_full;
                // Flush ends on writing the last centre, i.e. after WIDTH+2 writes.
                if (!out_full) begin
                    if (cen_col == COL_LAST && cen_row == ROW_LAST) begin
                        state_nx = DONE;
                    end else if (cen_col == COL_LAST) begin
                        col_nx = '0;
                        row_nx = cen_row + 1'b1;
                    end else begin
                        col_nx = cen_col + 1'b1;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign active_nx = (state_nx == RUN) || (state_nx == FLUSH);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            p           <= '0;
            cen_col     <= '0;
            cen_row     <= '0;
            border      <= 1'b0;
            pad_sel     <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            p           <= p_nx;
            cen_col     <= active_nx ? col_nx : '0;
            cen_row     <= active_nx ? row_nx : '0;
            border      <= active_nx && (col_nx == '0 || col_nx == COL_LAST ||
                                         row_nx == '0 || row_nx == ROW_LAST);
            pad_sel     <= (state_nx == FLUSH);
            frame_start <= (state == IDLE) && start;
            frame_done  <= (state_nx == DONE);
            busy        <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl at WIDTH=4, HEIGHT=3: directed frames push
// expected writes into a queue, a negedge monitor pops and compares them.
module tb_sobel_frame_ctrl;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_empty = 1'b0;
    logic       out_full = 1'b0;
    logic       in_rd_en, out_wr_en, px_advance, pad_sel;
    logic [2:0] cen_col;
    logic [1:0] cen_row;
    logic       border, frame_start, frame_done, busy;

    sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .CW(3), .RW(2), .PW(4)) dut (
        .clock(clk), .reset(reset), .start(start), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .out_full(out_full), .out_wr_en(out_wr_en),
        .px_advance(px_advance), .pad_sel(pad_sel), .cen_col(cen_col),
        .cen_row(cen_row), .border(border), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    int cyc = 0, rd_cnt = 0, wr_cnt = 0, adv_cnt = 0, fs_cnt = 0, done_cnt = 0;
    int fs_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0;
    logic       prev_busy = 1'b0, prev_wr = 1'b0;
    logic [2:0] prev_col = '0;
    logic [1:0] prev_row = '0;

    // Hand-derived border pattern for a 4x3 frame in raster order.
    int border_tbl[12] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; adv_cnt = 0; fs_cnt = 0; done_cnt = 0;
    endtask

    task automatic load_expected();
        exp_q.delete();
        for (int unsigned k = 0; k < 12; k++) begin
            int row, col, pad;
            row = int'(k) / W;
            col = int'(k) % W;
            pad = (k >= 6) ? 1 : 0;
            exp_q.push_back((row << 5) | (col << 2) | (border_tbl[k] << 1) | pad);
        end
    endtask

    function automatic int all_outs();
        return {in_rd_en, out_wr_en, px_advance, pad_sel, cen_col, cen_row,
                border, frame_start, frame_done, busy};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("adv_eq_rd_or_wr", int'(px_advance), int'(in_rd_en | out_wr_en));
            if (in_empty) chk("rd_while_empty", int'(in_rd_en), 0);
            if (out_full) chk("wr_while_full", int'(out_wr_en), 0);
            if (out_full && busy && wr_cnt > 0 && !pad_sel && !frame_done)
                chk("rd_while_full_run", int'(in_rd_en), 0);
            if (busy && prev_busy && !prev_wr)
                chk("coord_frozen", int'({cen_row, cen_col}), int'({prev_row, prev_col}));
            if (in_rd_en) rd_cnt++;
            if (px_advance) adv_cnt++;
            if (frame_start) begin
                fs_cnt++;
                fs_cyc = cyc;
            end
            if (out_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("write_row_col_border_pad",
                        int'({cen_row, cen_col, border, pad_sel}), e);
                end
                if (wr_cnt == 0) begin
                    chk("first_write_adv_index", adv_cnt, 7);
                    first_wr_cyc = cyc;
                end
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                chk("reads_per_frame", rd_cnt, 12);
                chk("writes_per_frame", wr_cnt, 12);
                chk("done_after_last_write", cyc - last_wr_cyc, 1);
            end
        end
        prev_busy = busy;
        prev_wr   = out_wr_en;
        prev_col  = cen_col;
        prev_row  = cen_row;
    end

    // mode 0: clean, 1: in_empty toggling, 2: out_full bursts, 3: start held high
    task automatic run_frame(input int mode);
        int full_left;
        bit rb, fb;
        full_left = 0; rb = 0; fb = 0;
        clear_counts();
        load_expected();
        in_empty = 1'b0;
        out_full = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        if (mode != 3) start = 1'b0;
        for (int unsigned i = 0; i < 300 && done_cnt == 0; i++) begin
            if (mode == 1) in_empty = ~in_empty;
            if (mode == 2) begin
                if (full_left == 0) begin
                    if (!rb && wr_cnt >= 2 && !pad_sel) begin
                        rb = 1; full_left = 5;
                    end else if (!fb && pad_sel && wr_cnt >= 8) begin
                        fb = 1; full_left = 5;
                    end
                end
                out_full = (full_left != 0);
                if (full_left != 0) full_left--;
            end
            @(posedge clk); #1;
        end
        if (done_cnt == 0) chk("frame_timeout", 0, 1);
        start = 1'b0;
        in_empty = 1'b0;
        out_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("frame_start_pulses", fs_cnt, 1);
        chk("frame_done_pulses", done_cnt, 1);
        chk("idle_after_frame", int'({busy, frame_done, frame_start}), 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        if (mode == 0) chk("first_write_latency", first_wr_cyc - fs_cyc, W + 2);
        if (mode == 2) chk("full_bursts_applied", int'({rb, fb}), 3);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_run();
        clear_counts();
        load_expected();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int unsigned i = 0; i < 100 && wr_cnt < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("reached_run_before_reset", int'(wr_cnt >= 3), 1);
        reset = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("outs_zero_mid_reset", all_outs(), 0);
        end
        @(posedge clk); #1;
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("outs_zero_reset", all_outs(), 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_frame(0);
        reset_mid_run();
        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
